// File: rtl/bf_pkg.sv
// Shared definitions for the BrainF core: opcode encoding, FSM states and default widths.
package bf_pkg;

  localparam int ADDR_W_DEF  = 16;
  localparam int DATA_W_DEF  = 8;
  localparam int DEPTH_W_DEF = 16;

  localparam logic [3:0] OP_HALT  = 4'd0;
  localparam logic [3:0] OP_INC   = 4'd1;
  localparam logic [3:0] OP_DEC   = 4'd2;
  localparam logic [3:0] OP_RIGHT = 4'd3;
  localparam logic [3:0] OP_LEFT  = 4'd4;
  localparam logic [3:0] OP_JZ    = 4'd5;
  localparam logic [3:0] OP_JNZ   = 4'd6;
  localparam logic [3:0] OP_OUT   = 4'd7;
  localparam logic [3:0] OP_IN    = 4'd8;

  typedef enum logic [2:0] {
    ST_LOAD  = 3'd0,
    ST_EXEC  = 3'd1,
    ST_SCANF = 3'd2,
    ST_SCANB = 3'd3,
    ST_OUTW  = 3'd4,
    ST_INW   = 3'd5,
    ST_HALT  = 3'd6
  } state_t;

endpackage

// File: rtl/bf_core.sv
// BrainF processor core: drives program/data addresses into a registered-read memory
// and moves '.'/',' bytes over valid/ready streams.
module bf_core import bf_pkg::*; #(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DEPTH_W = DEPTH_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [ADDR_W-1:0] pc,
  input  logic [3:0]        prg,
  output logic [ADDR_W-1:0] cursor,
  input  logic [DATA_W-1:0] mem,
  output logic [DATA_W-1:0] out,
  output logic              we,
  output logic [DATA_W-1:0] dout_data,
  output logic              dout_valid,
  input  logic              dout_ready,
  input  logic [DATA_W-1:0] din_data,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              halted,
  output logic              error
);

  localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);
  localparam logic [ADDR_W-1:0]  ADDR_ONE  = ADDR_W'(1);
  localparam logic [DATA_W-1:0]  DATA_ONE  = DATA_W'(1);

  // Returns {overflow, next_depth}; depth sticks at all-ones on overflow.
  function automatic logic [DEPTH_W:0] depth_inc(input logic [DEPTH_W-1:0] d);
    if (&d) return {1'b1, d};
    else    return {1'b0, d + DEPTH_ONE};
  endfunction

  state_t              state;
  logic [DEPTH_W-1:0]  depth;
  logic                scan_chk;
  logic                err_q;
  logic [DEPTH_W:0]    depth_up;

  assign depth_up   = depth_inc(depth);
  assign dout_valid = (state == ST_OUTW);
  assign dout_data  = mem;
  assign din_ready  = (state == ST_INW);
  assign halted     = (state == ST_HALT);
  assign error      = err_q;

  always_comb begin
    we  = 1'b0;
    out = '0;
    if (state == ST_EXEC && prg == OP_INC) begin
      we  = 1'b1;
      out = mem + DATA_ONE;
    end else if (state == ST_EXEC && prg == OP_DEC) begin
      we  = 1'b1;
      out = mem - DATA_ONE;
    end else if (state == ST_INW && din_valid) begin
      we  = 1'b1;
      out = din_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_LOAD;
      pc       <= '0;
      cursor   <= '0;
      depth    <= '0;
      scan_chk <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: state <= ST_EXEC;

        ST_EXEC: begin
          case (prg)
            OP_HALT:  state <= ST_HALT;
            OP_RIGHT: begin cursor <= cursor + ADDR_ONE; pc <= pc + ADDR_ONE; state <= ST_LOAD; end
            OP_LEFT:  begin cursor <= cursor - ADDR_ONE; pc <= pc + ADDR_ONE; state <= ST_LOAD; end
            OP_JZ: begin
              pc <= pc + ADDR_ONE;
              if (mem != '0) state <= ST_LOAD;
              else begin
                depth <= DEPTH_ONE;
                state <= ST_SCANF;
              end
            end
            OP_JNZ: begin
              if (mem == '0) begin
                pc    <= pc + ADDR_ONE;
                state <= ST_LOAD;
              end else if (pc == '0) begin
                // nothing can precede address 0, so this ']' has no partner
                err_q <= 1'b1;
                state <= ST_HALT;
              end else begin
                depth <= DEPTH_ONE;
                pc    <= pc - ADDR_ONE;
                state <= ST_SCANB;
              end
            end
            OP_OUT:  state <= ST_OUTW;
            OP_IN:   state <= ST_INW;
            default: begin pc <= pc + ADDR_ONE; state <= ST_LOAD; end
          endcase
        end

        // prg lags pc by one edge, so each scan position needs a wait cycle before its check
        ST_SCANF: begin
          if (!scan_chk) scan_chk <= 1'b1;
          else begin
            scan_chk <= 1'b0;
            case (prg)
              OP_HALT: begin err_q <= 1'b1; state <= ST_HALT; end
              OP_JZ: begin
                depth <= depth_up[DEPTH_W-1:0];
                if (depth_up[DEPTH_W]) begin err_q <= 1'b1; state <= ST_HALT; end
                else pc <= pc + ADDR_ONE;
              end
              OP_JNZ: begin
                depth <= depth - DEPTH_ONE;
                pc    <= pc + ADDR_ONE;
                if (depth == DEPTH_ONE) state <= ST_LOAD;
              end
              default: pc <= pc + ADDR_ONE;
            endcase
          end
        end

        ST_SCANB: begin
          if (!scan_chk) scan_chk <= 1'b1;
          else begin
            scan_chk <= 1'b0;
            if (prg == OP_JZ && depth == DEPTH_ONE) begin
              depth <= '0;
              pc    <= pc + ADDR_ONE;
              state <= ST_LOAD;
            end else if (prg == OP_JNZ && depth_up[DEPTH_W]) begin
              depth <= depth_up[DEPTH_W-1:0];
              err_q <= 1'b1;
              state <= ST_HALT;
            end else if (pc == '0) begin
              err_q <= 1'b1;
              state <= ST_HALT;
            end else begin
              if (prg == OP_JNZ)     depth <= depth_up[DEPTH_W-1:0];
              else if (prg == OP_JZ) depth <= depth - DEPTH_ONE;
              pc <= pc - ADDR_ONE;
            end
          end
        end

        ST_OUTW: if (dout_ready) begin pc <= pc + ADDR_ONE; state <= ST_LOAD; end
        ST_INW:  if (din_valid)  begin pc <= pc + ADDR_ONE; state <= ST_LOAD; end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_HALT;
      endcase
    end
  end

endmodule
